// File: rtl/imm_step_ctrl.sv
// Step controller for an immediate-generator demo: a small instruction table whose
// index is advanced by a debounced push-button and/or a periodic auto-advance timer.
module imm_step_ctrl #(
    parameter int DEPTH    = 16,
    parameter int DB_CYC   = 500000,
    parameter int AUTO_CYC = 50000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_n,
    input  logic                     auto_en,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [31:0]              wr_data,
    input  logic [$clog2(DEPTH):0]   len,
    output logic [31:0]              instr,
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic                     step
);

    localparam int AW  = $clog2(DEPTH);
    localparam int DCW = $clog2(DB_CYC + 1);
    localparam int ACW = $clog2(AUTO_CYC + 1);
    localparam logic [DCW-1:0] DB_LAST   = DCW'(DB_CYC - 1);
    localparam logic [ACW-1:0] AUTO_LAST = ACW'(AUTO_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } db_state_t;

    logic [31:0]    table_mem [DEPTH];

    logic           sync1_q, sync1_d;
    logic           sync2_q, sync2_d;
    db_state_t      state_q, state_d;
    logic [DCW-1:0] db_cnt_q, db_cnt_d;
    logic [ACW-1:0] auto_cnt_q, auto_cnt_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [31:0]    instr_q, instr_d;
    logic           step_q, step_d;

    logic           key_low;
    logic           key_evt;
    logic           auto_evt;
    logic           adv;
    logic [AW:0]    idx_inc;

    // Table has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        sync1_d  = key_n;
        sync2_d  = sync1_q;
        key_low  = ~sync2_q;
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        key_evt  = 1'b0;
        case (state_q)
            IDLE: begin
                db_cnt_d = '0;
                if (key_low) begin
                    state_d = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!key_low) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = PRESSED;
                    db_cnt_d = '0;
                    key_evt  = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                db_cnt_d = '0;
                if (!key_low) begin
                    state_d = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                // A low glitch during release returns to PRESSED silently.
                if (key_low) begin
                    state_d  = PRESSED;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                db_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        auto_evt = auto_en && (auto_cnt_q == AUTO_LAST);
        adv      = (key_evt || auto_evt) && (len != '0);
        idx_inc  = {1'b0, idx_q} + (AW + 1)'(1);

        idx_d = idx_q;
        if (adv) begin
            idx_d = (idx_inc >= len) ? '0 : idx_inc[AW-1:0];
        end else if ({1'b0, idx_q} >= len) begin
            idx_d = '0;
        end

        if (!auto_en || auto_evt || adv) begin
            auto_cnt_d = '0;
        end else begin
            auto_cnt_d = auto_cnt_q + 1'b1;
        end

        step_d  = adv;
        instr_d = table_mem[idx_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= IDLE;
            db_cnt_q   <= '0;
            auto_cnt_q <= '0;
            idx_q      <= '0;
            instr_q    <= '0;
            step_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            auto_cnt_q <= auto_cnt_d;
            idx_q      <= idx_d;
            instr_q    <= instr_d;
            step_q     <= step_d;
        end
    end

    assign instr = instr_q;
    assign idx   = idx_q;
    assign step  = step_q;

endmodule

// File: tb/tb_imm_step_ctrl.sv
// Directed bench for imm_step_ctrl with a short debounce and auto period.
module tb_imm_step_ctrl;

    localparam int DEPTH    = 4;
    localparam int DB_CYC   = 4;
    localparam int AUTO_CYC = 10;

    logic        clk;
    logic        rst;
    logic        key_n;
    logic        auto_en;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  len;
    logic [31:0] instr;
    logic [1:0]  idx;
    logic        step;

    int total_cnt;
    int bad_cnt;
    int step_cnt;

    imm_step_ctrl #(
        .DEPTH   (DEPTH),
        .DB_CYC  (DB_CYC),
        .AUTO_CYC(AUTO_CYC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .key_n  (key_n),
        .auto_en(auto_en),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .len    (len),
        .instr  (instr),
        .idx    (idx),
        .step   (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step === 1'b1) step_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until step is seen; n is the tick count, or -1 on timeout.
    task automatic wait_step(input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            tick();
            if (step === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic press();
        key_n = 1'b0;
        repeat (6) tick();
        key_n = 1'b1;
        repeat (14) tick();
    endtask

    logic [31:0] tbl [4];
    logic [1:0]  auto_exp [4];
    int n;
    int base;

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        step_cnt  = 0;
        tbl[0] = 32'hff9ff06f;
        tbl[1] = 32'h00000013;
        tbl[2] = 32'h00a00093;
        tbl[3] = 32'hfe000ee3;
        auto_exp[0] = 2'd1;
        auto_exp[1] = 2'd2;
        auto_exp[2] = 2'd0;
        auto_exp[3] = 2'd1;

        rst     = 1'b1;
        key_n   = 1'b1;
        auto_en = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        len     = 3'd0;
        repeat (2) tick();
        chk("rst_idx", 32'(idx), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_step", 32'(step), 32'd0);
        rst = 1'b0;

        // Table load, then idle
        len = 3'd4;
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_addr = 2'(i);
            wr_data = tbl[i];
            tick();
        end
        wr_en = 1'b0;
        repeat (2) tick();
        chk("load_instr", instr, 32'hff9ff06f);
        chk("load_idx", 32'(idx), 32'd0);
        chk("load_steps", 32'(step_cnt), 32'd0);

        // Too-short press
        base  = step_cnt;
        key_n = 1'b0;
        repeat (3) tick();
        key_n = 1'b1;
        repeat (10) tick();
        chk("short_steps", 32'(step_cnt - base), 32'd0);
        chk("short_idx", 32'(idx), 32'd0);

        // Valid press: step on the edge after release is driven
        base  = step_cnt;
        key_n = 1'b0;
        repeat (6) tick();
        key_n = 1'b1;
        wait_step(5, n);
        chk("press_lat", 32'(n), 32'd1);
        chk("press_idx", 32'(idx), 32'd1);
        chk("press_instr_old", instr, 32'hff9ff06f);
        tick();
        chk("press_instr", instr, 32'h00000013);
        repeat (12) tick();
        chk("press_steps", 32'(step_cnt - base), 32'd1);

        // Press with a bouncing release
        base  = step_cnt;
        key_n = 1'b0;
        repeat (6) tick();
        key_n = 1'b1;
        repeat (2) tick();
        key_n = 1'b0;
        tick();
        key_n = 1'b1;
        repeat (14) tick();
        chk("bounce_steps", 32'(step_cnt - base), 32'd1);
        chk("bounce_idx", 32'(idx), 32'd2);

        // Shrinking len below idx forces idx to 0 without a step
        base = step_cnt;
        len  = 3'd2;
        tick();
        chk("shrink_idx", 32'(idx), 32'd0);
        chk("shrink_step", 32'(step), 32'd0);
        tick();
        chk("shrink_instr", instr, 32'hff9ff06f);
        chk("shrink_steps", 32'(step_cnt - base), 32'd0);

        // Auto advance, len=3
        len     = 3'd3;
        auto_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_step(12, n);
            chk($sformatf("auto_lat%0d", k), 32'(n), 32'd10);
            chk($sformatf("auto_idx%0d", k), 32'(idx), 32'(auto_exp[k]));
        end

        // Key event lands on the same edge as the next auto event
        repeat (3) tick();
        key_n = 1'b0;
        repeat (6) tick();
        key_n = 1'b1;
        tick();
        chk("coin_step", 32'(step), 32'd1);
        chk("coin_idx", 32'(idx), 32'd2);
        tick();
        chk("coin_single", 32'(step), 32'd0);
        wait_step(12, n);
        chk("coin_restart", 32'(n), 32'd9);
        chk("coin_restart_idx", 32'(idx), 32'd0);
        auto_en = 1'b0;
        repeat (6) tick();

        // Reset in the middle of a press
        press();
        press();
        chk("pre_rst_idx", 32'(idx), 32'd2);
        key_n = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #2;
        chk("rst_mid_idx", 32'(idx), 32'd0);
        chk("rst_mid_instr", instr, 32'h0);
        chk("rst_mid_step", 32'(step), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        wait_step(10, n);
        chk("rst_fresh_lat", 32'(n), 32'd7);
        chk("rst_fresh_idx", 32'(idx), 32'd1);
        key_n = 1'b1;
        repeat (12) tick();

        // len=0 blocks every advance
        len = 3'd0;
        tick();
        chk("len0_idx", 32'(idx), 32'd0);
        base = step_cnt;
        press();
        press();
        auto_en = 1'b1;
        repeat (25) tick();
        auto_en = 1'b0;
        chk("len0_steps", 32'(step_cnt - base), 32'd0);
        chk("len0_idx_end", 32'(idx), 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
